// File: rtl/blocpu_pkg.sv
// Shared definitions for the program loader: default widths, stream
// constants, the nibble-check mask and the loader state encoding.
// The CSUM state exists only when BLOCPU_LOADER_CHECKSUM_EN is defined.
package blocpu_pkg;

  localparam int CPU_WIDTH_DEFAULT         = 8;
  localparam int INSTRUCTION_WIDTH_DEFAULT = 12;
  localparam int BYTE_WIDTH                = 8;
  localparam int COUNT_WIDTH               = 16;

  // Upper nibble of an instruction's first byte must be zero.
  localparam logic [BYTE_WIDTH-1:0] NIBBLE_CHECK_MASK = 8'hF0;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    LEN_HI   = 4'd1,
    LEN_LO   = 4'd2,
    INST_HI  = 4'd3,
    INST_LO  = 4'd4,
    WRITE    = 4'd5,
`ifdef BLOCPU_LOADER_CHECKSUM_EN
    CSUM     = 4'd6,
`endif
    CORE_RST = 4'd7,
    RUN_ARM  = 4'd8,
    RUN_WAIT = 4'd9,
    DONE     = 4'd10,
    ERROR    = 4'd11
  } state_t;

endpackage

// File: rtl/blocpu_loader_if.sv
// Host-side byte stream bundle for the loader: start request plus the
// byte/valid/ready pair. A byte moves only in a cycle where valid and
// ready are both high at the rising clock edge; the host may hold valid
// low for any number of cycles, and ready is driven by the loader alone.
interface blocpu_loader_if;
  logic       start;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output start, output byte_data, output byte_valid, input byte_ready);
  modport slave  (input start, input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/blocpu_loader.sv
// Program loader: receives a length-prefixed instruction stream from a
// host, writes each instruction into the core's instruction memory, then
// pulses the core reset, starts the core and waits for it to halt.
// Optional feature macro: BLOCPU_LOADER_CHECKSUM_EN adds a trailing
// XOR checksum byte over all instruction bytes.
module blocpu_loader
  import blocpu_pkg::*;
#(
  parameter int CPU_WIDTH         = CPU_WIDTH_DEFAULT,
  parameter int INSTRUCTION_WIDTH = INSTRUCTION_WIDTH_DEFAULT,
  parameter int ADDRESS_WIDTH     = 2 * CPU_WIDTH
) (
  input  logic                         in_clock,
  input  logic                         in_reset,
  input  logic                         in_start,
  input  logic [BYTE_WIDTH-1:0]        in_byte,
  input  logic                         in_byte_valid,
  output logic                         out_byte_ready,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
  output logic [ADDRESS_WIDTH-1:0]     out_instruction_address,
  output logic                         out_instruction_write,
  output logic                         out_core_reset,
  output logic                         out_core_running,
  input  logic                         in_core_running,
  output logic                         out_busy,
  output logic                         out_done,
  output logic                         out_error
);

  // Where the stream goes once all instructions are in.
`ifdef BLOCPU_LOADER_CHECKSUM_EN
  localparam state_t AFTER_LOAD = CSUM;
`else
  localparam state_t AFTER_LOAD = CORE_RST;
`endif

  state_t                         state_q, state_d;
  logic [COUNT_WIDTH-1:0]         count_q;   // instructions still to write
  logic [3:0]                     hi_q;      // instruction[11:8] held between bytes
  logic [INSTRUCTION_WIDTH-1:0]   instr_q;
  logic [ADDRESS_WIDTH-1:0]       addr_q;
  logic                           accept;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
  logic [BYTE_WIDTH-1:0]          csum_q;
`endif

  assign accept                  = in_byte_valid && out_byte_ready;
  assign out_instruction         = instr_q;
  assign out_instruction_address = addr_q;

  // State register; reset wins over a same-cycle start.
  always_ff @(posedge in_clock) begin
    if (in_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_d               = state_q;
    out_byte_ready        = 1'b0;
    out_instruction_write = 1'b0;
    out_core_reset        = 1'b0;
    out_core_running      = 1'b0;
    out_busy              = 1'b1;
    out_done              = 1'b0;
    out_error             = 1'b0;
    case (state_q)
      IDLE, DONE, ERROR: begin
        out_busy  = 1'b0;
        out_done  = (state_q == DONE);
        out_error = (state_q == ERROR);
        if (in_start) state_d = LEN_HI;
      end
      LEN_HI: begin
        out_byte_ready = 1'b1;
        if (accept) state_d = LEN_LO;
      end
      LEN_LO: begin
        out_byte_ready = 1'b1;
        if (accept) begin
          if ({count_q[COUNT_WIDTH-1:BYTE_WIDTH], in_byte} == '0) state_d = AFTER_LOAD;
          else                                                    state_d = INST_HI;
        end
      end
      INST_HI: begin
        out_byte_ready = 1'b1;
        if (accept) begin
          if ((in_byte & NIBBLE_CHECK_MASK) != '0) state_d = ERROR;
          else                                     state_d = INST_LO;
        end
      end
      INST_LO: begin
        out_byte_ready = 1'b1;
        if (accept) state_d = WRITE;
      end
      WRITE: begin
        out_instruction_write = 1'b1;
        if (count_q == COUNT_WIDTH'(1)) state_d = AFTER_LOAD;
        else                            state_d = INST_HI;
      end
`ifdef BLOCPU_LOADER_CHECKSUM_EN
      CSUM: begin
        out_byte_ready = 1'b1;
        if (accept) begin
          if (in_byte == csum_q) state_d = CORE_RST;
          else                   state_d = ERROR;
        end
      end
`endif
      CORE_RST: begin
        out_core_reset = 1'b1;
        state_d        = RUN_ARM;
      end
      RUN_ARM: begin
        out_core_running = 1'b1;
        if (in_core_running) state_d = RUN_WAIT;
      end
      RUN_WAIT: begin
        out_core_running = 1'b1;
        if (!in_core_running) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: count capture, instruction assembly, address and checksum.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      count_q <= '0;
      hi_q    <= '0;
      instr_q <= '0;
      addr_q  <= '0;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (in_start) begin
            addr_q <= '0;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
            csum_q <= '0;
`endif
          end
        end
        LEN_HI: if (accept) count_q[COUNT_WIDTH-1:BYTE_WIDTH] <= in_byte;
        LEN_LO: if (accept) count_q[BYTE_WIDTH-1:0] <= in_byte;
        INST_HI: begin
          if (accept) begin
            hi_q <= in_byte[3:0];
`ifdef BLOCPU_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ in_byte;
`endif
          end
        end
        INST_LO: begin
          if (accept) begin
            instr_q <= INSTRUCTION_WIDTH'({hi_q, in_byte});
`ifdef BLOCPU_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ in_byte;
`endif
          end
        end
        WRITE: begin
          addr_q  <= addr_q + ADDRESS_WIDTH'(1);
          count_q <= count_q - COUNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_blocpu_loader.sv
// Bench for blocpu_loader: directed streams plus random streams, each
// checked against a stream-level model that derives the expected writes,
// error outcome and final address from the byte stream itself.
module tb_blocpu_loader;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  blocpu_loader_if host();

  logic [11:0] out_instruction;
  logic [15:0] out_instruction_address;
  logic        out_instruction_write;
  logic        out_core_reset;
  logic        out_core_running;
  logic        in_core_running;
  logic        out_busy;
  logic        out_done;
  logic        out_error;

  blocpu_loader dut (
    .in_clock               (clock),
    .in_reset               (reset),
    .in_start               (host.start),
    .in_byte                (host.byte_data),
    .in_byte_valid          (host.byte_valid),
    .out_byte_ready         (host.byte_ready),
    .out_instruction        (out_instruction),
    .out_instruction_address(out_instruction_address),
    .out_instruction_write  (out_instruction_write),
    .out_core_reset         (out_core_reset),
    .out_core_running       (out_core_running),
    .in_core_running        (in_core_running),
    .out_busy               (out_busy),
    .out_done               (out_done),
    .out_error              (out_error)
  );

  // ---------------- scoreboard state ----------------
  int          err_count = 0;
  int          chk_count = 0;
  logic [27:0] exp_q[$];      // {address, instruction} in write order
  logic [7:0]  stim_q[$];     // full byte stream for the current case
  int          exp_consumed;  // bytes the loader will take before stopping
  bit          exp_err;
  int          exp_writes;
  int          write_seen;
  int          core_rst_seen;
  bit          prev_wr = 1'b0;
  bit          prev_crst = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_count++;
    assert (obs === exp) else begin
      err_count++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every strobe must match the next expected write and last one cycle.
  always @(negedge clock) begin
    if (out_instruction_write) begin
      write_seen++;
      if (exp_q.size() == 0) check("write_unexpected", 32'd1, 32'd0);
      else check("write_addr_instr", {4'd0, out_instruction_address, out_instruction},
                 {4'd0, exp_q.pop_front()});
      if (prev_wr) check("write_width", 32'd2, 32'd1);
    end
    if (out_core_reset) begin
      core_rst_seen++;
      if (prev_crst) check("core_reset_width", 32'd2, 32'd1);
    end
    prev_wr   = out_instruction_write;
    prev_crst = out_core_reset;
  end

  // ---------------- reference model ----------------
  // Walks the stream by its format rules: count, instruction pairs, and
  // (when enabled) the trailing XOR byte.
  task automatic build_model();
    int n, idx;
    logic [7:0] hi, lo, cs;
    exp_q.delete();
    n = {stim_q[0], stim_q[1]};
    idx = 2;
    cs = 8'h00;
    exp_err = 1'b0;
    exp_writes = 0;
    for (int i = 0; i < n; i++) begin
      hi = stim_q[idx];
      if (hi > 8'h0F) begin
        exp_err = 1'b1;
        idx++;
        break;
      end
      lo = stim_q[idx+1];
      exp_q.push_back({16'(i), hi[3:0], lo});
      exp_writes++;
      cs = cs ^ hi ^ lo;
      idx += 2;
    end
`ifdef BLOCPU_LOADER_CHECKSUM_EN
    if (!exp_err) begin
      if (stim_q[idx] != cs) exp_err = 1'b1;
      idx++;
    end
`endif
    exp_consumed = idx;
  endtask

  // Appends the checksum byte when the feature is built in.
  task automatic append_csum(input bit corrupt);
`ifdef BLOCPU_LOADER_CHECKSUM_EN
    logic [7:0] cs;
    cs = 8'h00;
    for (int i = 2; i < stim_q.size(); i++) cs = cs ^ stim_q[i];
    stim_q.push_back(corrupt ? ~cs : cs);
`else
    if (corrupt) stim_q.push_back(8'h00);
`endif
  endtask

  task automatic make_random(input int n, input bit bad);
    int bad_pos;
    logic [7:0] hi;
    stim_q.delete();
    stim_q.push_back(8'(n >> 8));
    stim_q.push_back(8'(n));
    bad_pos = $urandom_range(0, n - 1);
    for (int i = 0; i < n; i++) begin
      hi = {4'h0, 4'($urandom)};
      if (bad && i == bad_pos) hi[7:4] = 4'($urandom_range(1, 15));
      stim_q.push_back(hi);
      stim_q.push_back(8'($urandom));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at a negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    host.byte_data  = b;
    host.byte_valid = 1'b1;
    n = 0;
    while (!host.byte_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("byte_ready", {31'd0, host.byte_ready}, 32'd1);
    @(negedge clock);
    host.byte_valid = 1'b0;
    host.byte_data  = 8'h00;
    repeat (gap) @(negedge clock);
  endtask

  task automatic pulse_start();
    host.start = 1'b1;
    @(negedge clock);
    host.start = 1'b0;
  endtask

  // gap < 0 means a random valid gap before each byte.
  task automatic run_case(input string name, input int gap);
    int n;
    build_model();
    write_seen    = 0;
    core_rst_seen = 0;
    pulse_start();
    check({name, "_busy_load"}, {31'd0, out_busy}, 32'd1);
    for (int k = 0; k < exp_consumed; k++)
      send_byte(stim_q[k], (gap < 0) ? int'($urandom_range(0, 3)) : gap);
    if (exp_err) begin
      n = 0;
      while (!out_error && n < 10) begin @(negedge clock); n++; end
      check({name, "_error"}, {31'd0, out_error}, 32'd1);
      check({name, "_no_core_reset"}, core_rst_seen, 32'd0);
      check({name, "_no_run"}, {31'd0, out_core_running}, 32'd0);
    end else begin
      n = 0;
      while (!out_core_running && n < 10) begin @(negedge clock); n++; end
      check({name, "_running"}, {31'd0, out_core_running}, 32'd1);
      check({name, "_core_reset_once"}, core_rst_seen, 32'd1);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      in_core_running = 1'b1;
      repeat ($urandom_range(1, 8)) @(negedge clock);
      pulse_start();  // must be ignored while busy
      check({name, "_start_ignored"}, {30'd0, out_busy, out_core_running}, 32'd3);
      in_core_running = 1'b0;
      n = 0;
      while (!out_done && n < 10) begin @(negedge clock); n++; end
      check({name, "_done"}, {31'd0, out_done}, 32'd1);
      check({name, "_run_dropped"}, {31'd0, out_core_running}, 32'd0);
    end
    check({name, "_idle_flags"}, {31'd0, out_busy}, 32'd0);
    check({name, "_writes"}, write_seen, exp_writes);
    check({name, "_final_addr"}, {16'd0, out_instruction_address}, exp_writes);
    check({name, "_exp_left"}, exp_q.size(), 32'd0);
    repeat (2) @(negedge clock);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_outputs"},
          {out_instruction, out_instruction_address, out_instruction_write, out_core_reset,
           out_core_running, out_busy, out_done, out_error},
          32'd0);
    check({name, "_ready"}, {31'd0, host.byte_ready}, 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    host.start      = 1'b0;
    host.byte_data  = 8'h00;
    host.byte_valid = 1'b0;
    in_core_running = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    // Two instructions, back-to-back bytes
    stim_q = '{8'h00, 8'h02, 8'h08, 8'h2A, 8'h01, 8'h05};
    append_csum(1'b0);
    run_case("two_instr", 0);

    // Empty program still resets and runs the core
    stim_q = '{8'h00, 8'h00};
    append_csum(1'b0);
    run_case("empty", 0);

    // Bad upper nibble stops the load with no write
    stim_q = '{8'h00, 8'h01, 8'hF0, 8'h00};
    run_case("bad_nibble", 0);

    // Same two-instruction stream with 3-cycle valid gaps
    stim_q = '{8'h00, 8'h02, 8'h08, 8'h2A, 8'h01, 8'h05};
    append_csum(1'b0);
    run_case("gapped", 3);

`ifdef BLOCPU_LOADER_CHECKSUM_EN
    stim_q = '{8'h00, 8'h01, 8'h08, 8'h2A, 8'h22};
    run_case("csum_ok", 0);
    stim_q = '{8'h00, 8'h01, 8'h08, 8'h2A, 8'h23};
    run_case("csum_bad", 0);
`endif

    // Reset after the first write of a three-instruction stream
    stim_q = '{8'h00, 8'h03, 8'h0A, 8'h11, 8'h0B, 8'h22, 8'h0C, 8'h33};
    append_csum(1'b0);
    build_model();
    write_seen = 0;
    pulse_start();
    for (int k = 0; k < 4; k++) send_byte(stim_q[k], 0);
    n = 0;
    while (write_seen < 1 && n < 10) begin @(negedge clock); n++; end
    check("midreset_first_write", write_seen, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_all_zero("midreset");
    exp_q.delete();
    @(negedge clock);
    run_case("reload", 0);

    // Random streams with random gaps; some carry a bad nibble
    for (int it = 0; it < 8; it++) begin
      make_random($urandom_range(1, 6), ($urandom_range(0, 3) == 0));
      append_csum($urandom_range(0, 4) == 0);
      run_case($sformatf("rand%0d", it), -1);
    end

    $display("Result: errors=%0d of %0d checks", err_count, chk_count);
    $finish;
  end

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
